// File: rtl/obi_soc_demux.sv
// OBI address demultiplexer: base/mask decode onto N targets, an internal error responder
// for unmapped addresses, and an in-order response path with bounded outstanding count.
module obi_soc_demux #(
  parameter int unsigned N_TGT           = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_BASE = {32'h0030_0000, 32'h0020_0000,
                                                     32'h0010_0000, 32'h0000_0000},
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_MASK = {4{32'h0030_0000}},
  parameter logic [DATA_WIDTH-1:0]       ERR_RDATA = 32'hBADC_AB1E
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      init_req_i,
  output logic                                      init_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                     init_addr_i,
  input  logic                                      init_we_i,
  input  logic [DATA_WIDTH/8-1:0]                   init_be_i,
  input  logic [DATA_WIDTH-1:0]                     init_wdata_i,
  output logic                                      init_rvalid_o,
  output logic [DATA_WIDTH-1:0]                     init_rdata_o,
  output logic                                      init_err_o,
  output logic [N_TGT-1:0]                          tgt_req_o,
  input  logic [N_TGT-1:0]                          tgt_gnt_i,
  output logic [ADDR_WIDTH-1:0]                     tgt_addr_o,
  output logic                                      tgt_we_o,
  output logic [DATA_WIDTH/8-1:0]                   tgt_be_o,
  output logic [DATA_WIDTH-1:0]                     tgt_wdata_o,
  input  logic [N_TGT-1:0]                          tgt_rvalid_i,
  input  logic [N_TGT*DATA_WIDTH-1:0]               tgt_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o,
  output logic                                      spurious_o
);

  localparam int unsigned SelW = $clog2(N_TGT + 1);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SelW-1:0] SelErr = SelW'(N_TGT);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);

  logic [SelW-1:0]       sel;
  logic [SelW-1:0]       last_sel_q, last_sel_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic                  err_rvalid_q, err_rvalid_d;
  logic                  spurious_q, spurious_d;
  logic                  accept;
  logic                  handshake;
  logic                  gnt_sel;
  logic                  rvalid_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic [N_TGT-1:0]      last_oh;
  logic                  real_rvalid;
  logic                  stray;

  assign tgt_addr_o  = init_addr_i;
  assign tgt_we_o    = init_we_i;
  assign tgt_be_o    = init_be_i;
  assign tgt_wdata_o = init_wdata_i;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    sel = SelErr;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((init_addr_i & TGT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          TGT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        sel = SelW'(i);
      end
    end
  end

  // Only one target may be in flight at a time, so responses return in order without IDs.
  assign accept = (outstanding_q < CntMax) && ((outstanding_q == '0) || (sel == last_sel_q));

  always_comb begin
    tgt_req_o = '0;
    gnt_sel   = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel == SelW'(i)) begin
        tgt_req_o[i] = init_req_i & accept;
        gnt_sel      = tgt_gnt_i[i];
      end
    end
    if (sel == SelErr) begin
      init_gnt_o = init_req_i & accept;
    end else begin
      init_gnt_o = init_req_i & accept & gnt_sel;
    end
  end

  assign handshake = init_req_i & init_gnt_o;

  always_comb begin
    rvalid_sel = 1'b0;
    rdata_sel  = '0;
    last_oh    = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (last_sel_q == SelW'(i)) begin
        last_oh[i] = 1'b1;
        rvalid_sel = tgt_rvalid_i[i];
        rdata_sel  = tgt_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign real_rvalid   = rvalid_sel & (outstanding_q != '0);
  assign init_rvalid_o = err_rvalid_q | real_rvalid;
  assign init_rdata_o  = err_rvalid_q ? ERR_RDATA : rdata_sel;
  assign init_err_o    = err_rvalid_q;

  assign stray = (outstanding_q == '0) ? (|tgt_rvalid_i) : (|(tgt_rvalid_i & ~last_oh));

  always_comb begin
    last_sel_d    = handshake ? sel : last_sel_q;
    err_rvalid_d  = handshake & (sel == SelErr);
    spurious_d    = spurious_q | stray;
    outstanding_d = outstanding_q;
    case ({handshake, init_rvalid_o})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_sel_q    <= '0;
      outstanding_q <= '0;
      err_rvalid_q  <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      last_sel_q    <= last_sel_d;
      outstanding_q <= outstanding_d;
      err_rvalid_q  <= err_rvalid_d;
      spurious_q    <= spurious_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign spurious_o    = spurious_q;

endmodule

// File: doc/obi_soc_demux.md
# obi_soc_demux

Parametrised OBI address demultiplexer connecting the single unified SoC bus, after instruction/data arbitration, to N memory-mapped targets (IRAM, DRAM, UART, OBI-WB bridge, ...). Replaces fixed two-bit block selection with per-target base/mask decoding. Adds an error responder for unmapped addresses and a pipelined response path with up to MAX_OUTSTANDING in-flight transactions, kept in order.

## Interface
Parameters:
- N_TGT, 4, number of target ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..7)
- TGT_BASE, {32'h0030_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000}, packed N_TGT*ADDR_WIDTH; target i at slice i
- TGT_MASK, {4{32'h0030_0000}}, packed N_TGT*ADDR_WIDTH decode masks
- ERR_RDATA, 32'hBADC_AB1E, read data returned for unmapped accesses

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- init_req_i  in  1  initiator request
- init_gnt_o  out  1  initiator grant
- init_addr_i  in  ADDR_WIDTH  address
- init_we_i  in  1  write enable
- init_be_i  in  DATA_WIDTH/8  byte enables
- init_wdata_i  in  DATA_WIDTH  write data
- init_rvalid_o  out  1  response valid
- init_rdata_o  out  DATA_WIDTH  response data
- init_err_o  out  1  response is a decode error (qualified by init_rvalid_o)
- tgt_req_o  out  N_TGT  per-target request
- tgt_gnt_i  in  N_TGT  per-target grant
- tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o  out  as initiator  broadcast copies of the initiator fields
- tgt_rvalid_i  in  N_TGT  per-target response valid
- tgt_rdata_i  in  N_TGT*DATA_WIDTH  per-target read data, slice i
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- spurious_o  out  1  sticky flag: a response arrived that no outstanding transaction expects

## Operation
- Decode: target i hits when (init_addr_i & MASK_i) == BASE_i. Lowest index wins on multiple hits. No hit selects the internal error target ERR (index N_TGT).
- Accept condition: outstanding < MAX_OUTSTANDING and (outstanding == 0 or sel == last_sel). Switching targets therefore drains all responses first, which guarantees in-order return without an ID FIFO.
- Request to a real target: tgt_req_o[sel] = init_req_i & accept; all other tgt_req_o bits are 0. init_gnt_o = tgt_gnt_i[sel] & accept.
- Request to ERR: init_gnt_o = init_req_i & accept; no tgt_req_o bit is asserted. Writes are discarded.
- Handshake = init_req_i & init_gnt_o. On a handshake, last_sel <= sel.
- Counter: +1 on handshake, -1 on init_rvalid_o, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING and never goes below 0.
- Response for a real target: init_rvalid_o = tgt_rvalid_i[last_sel] & (outstanding != 0). init_rdata_o = tgt_rdata_i slice last_sel. init_err_o = 0.
- Response for ERR: err_rvalid_q <= handshake & (sel == ERR). init_rvalid_o = err_rvalid_q. init_rdata_o = ERR_RDATA. init_err_o = 1.
- Spurious response: any tgt_rvalid_i bit is high with outstanding == 0, or a bit other than last_sel is high. Either case sets spurious_o until reset. Such responses are not forwarded.
- Reset mid-operation: the counter, last_sel, err_rvalid_q and spurious_o are cleared. Targets must share the same reset. Late target responses after reset are flagged as spurious.

## Timing
- Reset values: init_rvalid_o 0, init_err_o 0, outstanding_o 0, spurious_o 0, last_sel 0. init_gnt_o and tgt_req_o are 0 while init_req_i is 0.
- Request path (addr/req to tgt_req_o, tgt_gnt_i to init_gnt_o) is combinational: zero added latency.
- Response path for real targets is combinational: zero added latency.
- Error response arrives exactly 1 cycle after its grant. Back-to-back ERR grants produce back-to-back rvalids.
- Throughput is 1 transaction per cycle to the same target when the target sustains it. A target switch costs the drain time of the outstanding responses.

## Test plan
- DRAM read at 0x0000_0010 (target 0, 1-cycle gnt, rvalid next cycle, rdata 0x1234_5678): tgt_req_o = 4'b0001; init_rvalid_o is seen 1 cycle after the grant with rdata 0x1234_5678 and init_err_o = 0; outstanding_o returns 0 -> 1 -> 0.
- Unmapped 0x0040_0000 with TGT_MASK = 32'h0070_0000 on all targets: init_gnt_o is high in the request cycle, tgt_req_o stays 0, the next cycle shows rvalid = 1, err = 1, rdata = 0xBADC_AB1E.
- Pipelined reads to target 1 with the response delayed 2 cycles and MAX_OUTSTANDING = 2: the third request is not granted until the first rvalid; outstanding_o peaks at 2 and never reads 3.
- Target switch: read target 1 (outstanding 1) then request target 2: tgt_req_o[2] is held 0 until target 1 rvalid, then granted the same cycle the count reaches 0.
- Simultaneous handshake and response: outstanding_o stays constant. A stray tgt_rvalid_i[3] with count 0 sets spurious_o = 1, init_rvalid_o stays 0, and the flag clears only on rst_i.
- Assert rst_i with 2 outstanding: the next cycle shows outstanding_o = 0, init_rvalid_o = 0, spurious_o = 0.
